// File: rtl/alu_nibble_sequencer_if.sv
// Bundle of the upstream request, downstream result and 74181 slice signals
// around alu_nibble_sequencer; slave is the sequencer side, master the surroundings.
interface alu_nibble_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_s;
  logic             in_m;
  logic             in_cn_n;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_f;
  logic             out_cout_n;
  logic             out_aeqb;

  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_s;
  logic             alu_m;
  logic             alu_cn_n;
  logic [3:0]       alu_f;
  logic             alu_cn4_n;
  logic             alu_aeqb;

  modport slave (
    input  in_valid, in_a, in_b, in_s, in_m, in_cn_n,
    output in_ready,
    output out_valid, out_f, out_cout_n, out_aeqb,
    input  out_ready,
    output alu_a, alu_b, alu_s, alu_m, alu_cn_n,
    input  alu_f, alu_cn4_n, alu_aeqb
  );

  modport master (
    output in_valid, in_a, in_b, in_s, in_m, in_cn_n,
    input  in_ready,
    input  out_valid, out_f, out_cout_n, out_aeqb,
    output out_ready,
    input  alu_a, alu_b, alu_s, alu_m, alu_cn_n,
    output alu_f, alu_cn4_n, alu_aeqb
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a WIDTH-bit operation through one external 4-bit 74181 slice, LSB nibble
// first, chaining the active-low carry through a register between passes.
module alu_nibble_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  alu_nibble_sequencer_if.slave bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]              state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg;
  logic                    carry_reg;
  logic                    aeqb_reg;
  logic [NIBBLES-1:0][3:0] f_reg;
  logic [NIBBLES-1:0][3:0] a_reg;
  logic [NIBBLES-1:0][3:0] b_reg;
  logic [3:0]              s_reg;
  logic                    m_reg;

  logic idle, running, done, accept, last_pass;

  assign idle      = (state_reg == ST_IDLE);
  assign running   = (state_reg == ST_RUN);
  assign done      = (state_reg == ST_DONE);
  assign accept    = idle & bus.in_valid;
  assign last_pass = running & (idx_reg == IDX_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.in_valid)  state_next = ST_RUN;
      ST_RUN:  if (last_pass)     state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b1;
      aeqb_reg  <= 1'b0;
      f_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      m_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= bus.in_a;
        b_reg     <= bus.in_b;
        s_reg     <= bus.in_s;
        m_reg     <= bus.in_m;
        carry_reg <= bus.in_cn_n;
        idx_reg   <= '0;
        aeqb_reg  <= 1'b1;
        f_reg     <= '0;
      end else if (running) begin
        // Carry is chained in logic mode too; the slice ignores Cn when M=1.
        f_reg[idx_reg] <= bus.alu_f;
        carry_reg      <= bus.alu_cn4_n;
        aeqb_reg       <= aeqb_reg & bus.alu_aeqb;
        idx_reg        <= last_pass ? '0 : idx_reg + 1'b1;
      end
    end
  end

  assign bus.in_ready   = idle;
  assign bus.out_valid  = done;
  assign bus.out_f      = done ? f_reg : '0;
  assign bus.out_cout_n = done ? carry_reg : 1'b1;
  assign bus.out_aeqb   = done ? aeqb_reg : 1'b0;

  // The slice sees all-zero inputs whenever no pass is in progress.
  assign bus.alu_a    = running ? a_reg[idx_reg] : 4'h0;
  assign bus.alu_b    = running ? b_reg[idx_reg] : 4'h0;
  assign bus.alu_s    = running ? s_reg : 4'h0;
  assign bus.alu_m    = running ? m_reg : 1'b0;
  assign bus.alu_cn_n = running ? carry_reg : 1'b0;
endmodule
